// File: rtl/change_trace_fifo.sv
// change_trace_fifo
//   Value-change recorder. Samples `watch` on every rising edge and logs a
//   timestamped record into a circular FIFO whenever the sample differs from
//   the previous one. The first edge after reset always logs a record
//   (first=1, ts=0), in the manner of $monitor.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   watch            : bus under observation
//   out_valid/ready  : consumer handshake for the head record
//   out_ts/value/first : head record fields (don't-care while !out_valid)
//   overflow         : sticky, a record was dropped since reset
//   drops            : dropped-record count, saturating
//   level            : FIFO occupancy
//   o_dbg_state      : FSM state (0 = PRIME, 1 = RUN)
//
// Handshake: a record transfers on a rising edge where out_valid && out_ready.
// out_* hold steady while out_valid && !out_ready; out_ready with
// out_valid=0 has no effect.

module change_trace_fifo #(
  parameter int W      = 3,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             watch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic [W-1:0]             out_value,
  output logic                     out_first,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drops,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  logic [W-1:0]      r_prev;
  logic [TS_W-1:0]   r_ts;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drops;

  logic [TS_W-1:0]   r_mem_ts  [DEPTH];
  logic [W-1:0]      r_mem_val [DEPTH];
  logic [DEPTH-1:0]  r_mem_first;

  logic w_pop;
  logic w_push_req;
  logic w_room;
  logic w_push_ok;
  logic w_drop;
  logic w_first;

  assign w_first    = (r_state == ST_PRIME);
  assign w_pop      = (r_level != '0) && out_ready;
  // Case-inequality so an X/Z sample in simulation counts as a change only
  // when it really differs; synthesis reduces this to a plain compare.
  assign w_push_req = w_first || (watch !== r_prev);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_room     = (r_level < LW'(DEPTH)) || w_pop;
  assign w_push_ok  = w_push_req && w_room;
  assign w_drop     = w_push_req && !w_room;

  // Storage carries no reset: contents are only observed through out_valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem_ts[r_wptr]    <= r_ts;
      r_mem_val[r_wptr]   <= watch;
      r_mem_first[r_wptr] <= w_first;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_PRIME;
      r_prev     <= '0;
      r_ts       <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else begin
      r_state <= ST_RUN;
      r_prev  <= watch;
      r_ts    <= r_ts + 1'b1;
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(w_push_ok) - LW'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != '1) r_drops <= r_drops + 1'b1;
      end
    end
  end

  assign out_valid   = (r_level != '0);
  assign out_ts      = r_mem_ts[r_rptr];
  assign out_value   = r_mem_val[r_rptr];
  assign out_first   = out_valid && r_mem_first[r_rptr];
  assign overflow    = r_overflow;
  assign drops       = r_drops;
  assign level       = r_level;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_change_trace_fifo.sv
module tb_change_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  watch;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_ts;
  logic [2:0]  out_value;
  logic        out_first;
  logic        overflow;
  logic [7:0]  drops;
  logic [3:0]  level;
  logic        dbg_state;

  // second instance with a 4-bit timestamp for wrap checks
  logic [2:0]  w2;
  logic        r2;
  logic        v2;
  logic [3:0]  ts2;
  logic [2:0]  val2;
  logic        f2;
  logic        ov2;
  logic [7:0]  dr2;
  logic [3:0]  lv2;
  logic        st2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  change_trace_fifo dut (
    .clk(clk), .rst(rst), .watch(watch), .out_valid(out_valid),
    .out_ready(out_ready), .out_ts(out_ts), .out_value(out_value),
    .out_first(out_first), .overflow(overflow), .drops(drops),
    .level(level), .o_dbg_state(dbg_state)
  );

  change_trace_fifo #(.TS_W(4)) dut_w (
    .clk(clk), .rst(rst), .watch(w2), .out_valid(v2),
    .out_ready(r2), .out_ts(ts2), .out_value(val2),
    .out_first(f2), .overflow(ov2), .drops(dr2),
    .level(lv2), .o_dbg_state(st2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves rst high after two edges; caller sets inputs then drops rst
  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b0; watch = 3'd0; w2 = 3'd0; r2 = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, out_first, overflow, drops, level, dbg_state} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b f=%0b ov=%0b drops=%0d level=%0d st=%0b, expected all 0",
               out_valid, out_first, overflow, drops, level, dbg_state);
    end
  endtask

  task automatic test_hold();
    int n_rec = 0;
    do_reset();
    watch = 3'b011; out_ready = 1'b1; rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) begin
        n_rec++;
        n_checks++;
        if ({out_first, out_ts, out_value} !== {1'b1, 16'd0, 3'b011}) begin
          n_fail++;
          $display("FAIL hold_record: got first=%0b ts=%0d val=%0h, expected first=1 ts=0 val=3",
                   out_first, out_ts, out_value);
        end
      end
    end
    n_checks++;
    if (n_rec !== 1) begin
      n_fail++;
      $display("FAIL hold_count: got %0d records, expected 1", n_rec);
    end
    n_checks++;
    if (level !== 4'd0) begin
      n_fail++;
      $display("FAIL hold_level: got %0d, expected 0", level);
    end
  endtask

  task automatic test_steps();
    logic [2:0] vals [3] = '{3'd5, 3'd0, 3'd1};
    do_reset();
    out_ready = 1'b1; rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      watch = vals[k];
      tick();
      n_checks++;
      if ({out_valid, out_first, out_ts, out_value, level} !==
          {1'b1, (k == 0), 16'(k), vals[k], 4'd1}) begin
        n_fail++;
        $display("FAIL step_%0d: got v=%0b first=%0b ts=%0d val=%0d level=%0d, expected v=1 first=%0b ts=%0d val=%0d level=1",
                 k, out_valid, out_first, out_ts, out_value, level, (k == 0), k, vals[k]);
      end
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL step_drain: got out_valid=%0b, expected 0", out_valid);
    end
  endtask

  // overflow, then full-with-pop acceptance, then ordered drain
  task automatic test_overflow();
    do_reset();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      watch = 3'(k);
      tick();
    end
    n_checks++;
    if ({level, overflow, drops} !== {4'd8, 1'b1, 8'd4}) begin
      n_fail++;
      $display("FAIL ovf_state: got level=%0d ov=%0b drops=%0d, expected level=8 ov=1 drops=4",
               level, overflow, drops);
    end
    n_checks++;
    if ({out_valid, out_first, out_ts, out_value} !== {1'b1, 1'b1, 16'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL ovf_head0: got v=%0b first=%0b ts=%0d val=%0d, expected v=1 first=1 ts=0 val=0",
               out_valid, out_first, out_ts, out_value);
    end
    // back-pressure: head must not move
    tick();
    n_checks++;
    if ({out_first, out_ts, out_value, level} !== {1'b1, 16'd0, 3'd0, 4'd8}) begin
      n_fail++;
      $display("FAIL ovf_stall: got first=%0b ts=%0d val=%0d level=%0d, expected first=1 ts=0 val=0 level=8",
               out_first, out_ts, out_value, level);
    end
    // full + pop + change on the same edge (ts=13 here after the stall edge)
    out_ready = 1'b1; watch = 3'd6;
    tick();
    n_checks++;
    if ({level, drops} !== {4'd8, 8'd4}) begin
      n_fail++;
      $display("FAIL full_pop: got level=%0d drops=%0d, expected level=8 drops=4", level, drops);
    end
    for (int j = 1; j <= 8; j++) begin
      logic [15:0] e_ts;
      logic [2:0]  e_val;
      e_ts  = (j == 8) ? 16'd13 : 16'(j);
      e_val = (j == 8) ? 3'd6 : 3'(j);
      n_checks++;
      if ({out_valid, out_first, out_ts, out_value} !== {1'b1, 1'b0, e_ts, e_val}) begin
        n_fail++;
        $display("FAIL drain_%0d: got v=%0b first=%0b ts=%0d val=%0d, expected v=1 first=0 ts=%0d val=%0d",
                 j, out_valid, out_first, out_ts, out_value, e_ts, e_val);
      end
      tick();
    end
    n_checks++;
    if ({out_valid, level, overflow, drops} !== {1'b0, 4'd0, 1'b1, 8'd4}) begin
      n_fail++;
      $display("FAIL drain_end: got v=%0b level=%0d ov=%0b drops=%0d, expected v=0 level=0 ov=1 drops=4",
               out_valid, level, overflow, drops);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      watch = 3'(k + 1);
      tick();
    end
    // a few more changes to force drops before reset
    for (int k = 0; k < 6; k++) begin
      watch = 3'(k);
      tick();
    end
    n_checks++;
    if ({level, overflow} !== {4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_pre: got level=%0d ov=%0b, expected level=8 ov=1", level, overflow);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, level, overflow, drops} !== {1'b0, 4'd0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b level=%0d ov=%0b drops=%0d, expected all 0",
               out_valid, level, overflow, drops);
    end
    rst = 1'b0; watch = 3'd5;
    tick();
    n_checks++;
    if ({out_valid, out_first, out_ts, out_value} !== {1'b1, 1'b1, 16'd0, 3'd5}) begin
      n_fail++;
      $display("FAIL mid_first: got v=%0b first=%0b ts=%0d val=%0d, expected v=1 first=1 ts=0 val=5",
               out_valid, out_first, out_ts, out_value);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    w2 = 3'd1;
    tick();
    n_checks++;
    if ({v2, f2, ts2, val2} !== {1'b1, 1'b0, 4'd15, 3'd1}) begin
      n_fail++;
      $display("FAIL wrap_15: got v=%0b first=%0b ts=%0d val=%0d, expected v=1 first=0 ts=15 val=1",
               v2, f2, ts2, val2);
    end
    w2 = 3'd2;
    tick();
    n_checks++;
    if ({v2, f2, ts2, val2, ov2} !== {1'b1, 1'b0, 4'd0, 3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_0: got v=%0b first=%0b ts=%0d val=%0d ov=%0b, expected v=1 first=0 ts=0 val=2 ov=0",
               v2, f2, ts2, val2, ov2);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_steps();
    test_overflow();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
